fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage + IF/ID pipeline register; direct consumer of hazard_unit stall_f/stall_d/flush_d.
//  Issues instruction fetches over a valid/ready request + valid response channel, max one outstanding.
//  Redirects on pc_src_e/pc_target_e; drives instr/pc into ID.
//  1-entry hold buffer absorbs a response that arrives during stall_d.
// PARAMETERS
//  XLEN       32            address/data width
//  RESET_PC   32'h0000_0000 first fetch address after rst
//  NOP_INSTR  32'h0000_0013 addi x0,x0,0; bubble value for instr_d
// PORTS
//  clk             in   1     single clock, rising edge
//  rst             in   1     synchronous, active-high reset
//  stall_f         in   1     hold fetch (no new request)
//  stall_d         in   1     hold IF/ID register
//  flush_d         in   1     clear IF/ID to bubble
//  pc_src_e        in   1     taken branch/jump from EX
//  pc_target_e     in   XLEN  redirect address
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address (= pc_f)
//  imem_rsp_valid  in   1     response data valid
//  imem_rsp_data   in   32    instruction word
//  instr_d         out  32    IF/ID instruction
//  pc_d            out  XLEN  IF/ID pc
//  pc_plus4_d      out  XLEN  IF/ID pc+4
//  valid_d         out  1     IF/ID holds real instruction
// BEHAVIOUR
//  Reset (sync, priority over everything): pc_f=RESET_PC, state=S_REQ, hold_valid=0,
//   instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, imem_req_valid=0 in the rst cycle.
//   rst mid-fetch: in-flight response after rst is ignored; bench memory must drop it too.
//  FSM states:
//   S_REQ  = nothing outstanding
//   S_WAIT = one request outstanding
//   S_DROP = outstanding response to be discarded
//  imem_req_valid = !rst & !pc_src_e & !stall_f & !hold_valid &
//   (S_REQ | (S_WAIT & imem_rsp_valid & accept)).
//   accept = !stall_d & !flush_d.
//   Back-to-back issue: 1 instr/cycle with 1-cycle memory.
//  Request handshake (valid&ready): pc_inflight<=pc_f; pc_f<=pc_f+4 (mod 2^XLEN); ->S_WAIT.
//   Otherwise S_WAIT+rsp -> S_REQ.
//  Response in S_WAIT, per cycle:
//   flush_d    : discard response.
//   stall_d    : load hold buffer {imem_rsp_data, pc_inflight}; hold_valid<=1.
//   otherwise  : load IF/ID (valid_d=1, pc_plus4_d=pc_inflight+4).
//  Hold drain: first cycle with hold_valid & !stall_d & !flush_d -> IF/ID loads from hold;
//   hold_valid<=0; next request may issue the following cycle.
//  IF/ID priority per cycle: rst > flush_d (bubble: NOP_INSTR, valid_d=0, pc fields 0) >
//   stall_d (hold) > hold-buffer drain > response > bubble (no data: valid_d=0).
//  Redirect pc_src_e (priority over stall_f/stall_d):
//   pc_f<=pc_target_e; hold_valid<=0; no request issued that cycle.
//   Next state by current state:
//    S_WAIT, no rsp this cycle -> S_DROP
//    S_WAIT, rsp this cycle    -> discard rsp, S_REQ
//    S_DROP                    -> stay S_DROP
//    S_REQ                     -> stay S_REQ
//  S_DROP: no requests; on imem_rsp_valid discard, ->S_REQ.
//  Misaligned pc_target_e passed through unchecked; flush_d w/o pc_src_e only bubbles IF/ID.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs
//   perf_fetch_cnt[31:0] : +1 per IF/ID load with valid_d=1
//   perf_bubble_cnt[31:0]: +1 per cycle valid_d=0 after reset
//   Both wrap at 2^32; reset to 0.
//  FETCH_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package riscv_pkg:
//   NOP_INSTR constant, XLEN default
//   fetch_state_t enum {S_REQ, S_WAIT, S_DROP}
//  Sub-module fetch_hold_buf: 1-entry {instr,pc} buffer with load/drain/clear, valid flag.
//  FSM, pc_f/pc_inflight, IF/ID register stay in fetch_stage.
// TESTING
//  1. Reset, ready=1, 1-cycle mem returning addr as data
//     -> imem_req_addr 0,4,8,...; pc_d advances by 4 each cycle; valid_d=1 from cycle 3.
//  2. stall_f=stall_d=1 for 3 cycles with response arriving in first
//     -> hold_valid=1, no req, IF/ID unchanged; on release IF/ID gets held word, then fetch resumes.
//  3. pc_src_e=1, pc_target_e=32'h100 while request to 0x10 outstanding (rsp 2 cycles late)
//     -> S_DROP, 0x10 data never reaches instr_d; next req addr 0x100.
//  4. flush_d=1 with valid_d=1 -> next cycle instr_d=32'h13, valid_d=0, pc_d=0.
//  5. imem_req_ready=0 for 4 cycles -> req_valid/addr stable; pc_f not incremented.
//  6. rst asserted in S_WAIT -> next cycle all outputs at reset values; req addr RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants and fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {instr,pc} buffer with load/drain/clear and a valid flag
module fetch_hold_buf #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  always_comb begin
    valid_d = clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid_q;
    instr_d = load ? load_instr : instr_q;
    pc_d    = load ? load_pc : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with one-outstanding imem fetch, redirect/drop FSM and IF/ID register.
// Optional perf counters when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);
  import riscv_pkg::*;
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d, pc_inflight_q, pc_inflight_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d, if_pc4_q, if_pc4_d;
  logic            if_valid_q, if_valid_d;
  logic            hold_valid, hold_load, hold_drain;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            accept, rsp_wait, live_rsp, req_fire, if_keep, new_valid;
  logic [31:0]     new_instr;
  logic [XLEN-1:0] new_pc;
  always_comb begin
    accept         = !stall_d && !flush_d;
    rsp_wait       = state_q == S_WAIT && imem_rsp_valid;
    live_rsp       = rsp_wait && !pc_src_e;
    imem_req_valid = !rst && !pc_src_e && !stall_f && !hold_valid &&
                     (state_q == S_REQ || (rsp_wait && accept));
    req_fire       = imem_req_valid && imem_req_ready;
    hold_drain     = hold_valid && accept && !pc_src_e;
    hold_load      = live_rsp && stall_d && !flush_d;
    // a redirect with a response still in flight must swallow that response later
    state_d        = pc_src_e ? ((state_q != S_REQ && !imem_rsp_valid) ? S_DROP : S_REQ)
                   : req_fire ? S_WAIT
                   : (state_q != S_REQ && imem_rsp_valid) ? S_REQ : state_q;
    pc_f_d         = pc_src_e ? pc_target_e : req_fire ? pc_f_q + XLEN'(4) : pc_f_q;
    pc_inflight_d  = req_fire ? pc_f_q : pc_inflight_q;
    new_valid      = hold_drain || (live_rsp && accept);
    new_instr      = hold_drain ? hold_instr : new_valid ? imem_rsp_data : NOP_INSTR;
    new_pc         = hold_drain ? hold_pc : new_valid ? pc_inflight_q : '0;
    if_keep        = stall_d && !flush_d;
    if_valid_d     = if_keep ? if_valid_q : new_valid;
    if_instr_d     = if_keep ? if_instr_q : new_instr;
    if_pc_d        = if_keep ? if_pc_q : new_pc;
    if_pc4_d       = if_keep ? if_pc4_q : new_valid ? new_pc + XLEN'(4) : '0;
  end
  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .drain      (hold_drain),
    .clear      (pc_src_e),
    .load_instr (imem_rsp_data),
    .load_pc    (pc_inflight_q),
    .valid      (hold_valid),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_f_q        <= RESET_PC;
      pc_inflight_q <= '0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= '0;
      if_pc4_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      pc_inflight_q <= pc_inflight_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc4_q      <= if_pc4_d;
    end
  end
  assign imem_req_addr = pc_f_q;
  assign instr_d       = if_instr_q;
  assign pc_d          = if_pc_q;
  assign pc_plus4_d    = if_pc4_q;
  assign valid_d       = if_valid_q;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, !if_keep && new_valid};
    bubble_cnt_d = bubble_cnt_q + {31'd0, !if_valid_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif
endmodule
